// File: rtl/cell_test_sequencer_if.sv
// Harness-side signal bundle for the AOI21 cell self-test sequencer.
// START is a level request that is sampled only while the sequencer is idle.
// DONE is a single-cycle completion pulse. Results stay stable until the next accepted START.
interface cell_test_sequencer_if;
  logic       START;
  logic       ABORT;
  logic       Y_IN;
  logic       A;
  logic       B1;
  logic       B2;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_CNT;
  logic       FAIL_VLD;
  logic [2:0] FAIL_VEC;
  logic [1:0] dbgState;

  modport master (
    output START, ABORT, Y_IN,
    input  A, B1, B2, BUSY, DONE, PASS, ERR_CNT, FAIL_VLD, FAIL_VEC, dbgState
  );

  modport slave (
    input  START, ABORT, Y_IN,
    output A, B1, B2, BUSY, DONE, PASS, ERR_CNT, FAIL_VLD, FAIL_VEC, dbgState
  );
endinterface

// File: rtl/cell_test_sequencer.sv
// Walks all 8 AOI21 input vectors, samples the synchronised cell output after a
// programmable settle time, and records the mismatch count, first failing vector and pass flag.
module cell_test_sequencer #(
  parameter logic [7:0] TRUTH         = 8'h07,
  parameter int         SETTLE_CYCLES = 4
) (
  input logic                 CLK,
  input logic                 RST_N,
  cell_test_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  state_t     state, stateNext;
  logic [2:0] vec, vecNext;
  logic [7:0] settleCnt, settleCntNext;
  logic [1:0] ySync;
  logic [3:0] errCnt, errCntNext;
  logic       failVld, failVldNext;
  logic [2:0] failVec, failVecNext;
  logic       pass, passNext;
  logic [2:0] cellIn, cellInNext;
  logic       mismatch;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      vec       <= 3'd0;
      settleCnt <= 8'd0;
      ySync     <= 2'b00;
      errCnt    <= 4'd0;
      failVld   <= 1'b0;
      failVec   <= 3'd0;
      pass      <= 1'b0;
      cellIn    <= 3'd0;
    end else begin
      state     <= stateNext;
      vec       <= vecNext;
      settleCnt <= settleCntNext;
      ySync     <= {ySync[0], bus.Y_IN};
      errCnt    <= errCntNext;
      failVld   <= failVldNext;
      failVec   <= failVecNext;
      pass      <= passNext;
      cellIn    <= cellInNext;
    end
  end

  always_comb begin
    stateNext     = state;
    vecNext       = vec;
    settleCntNext = settleCnt;
    errCntNext    = errCnt;
    failVldNext   = failVld;
    failVecNext   = failVec;
    passNext      = pass;
    mismatch      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.START) begin
          vecNext       = 3'd0;
          errCntNext    = 4'd0;
          failVldNext   = 1'b0;
          failVecNext   = 3'd0;
          passNext      = 1'b0;
          settleCntNext = 8'(SETTLE_CYCLES - 1);
          stateNext     = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.ABORT) begin
          passNext  = 1'b0;
          stateNext = IDLE;
        end else if (settleCnt == 8'd0) begin
          stateNext = SAMPLE;
        end else begin
          settleCntNext = settleCnt - 8'd1;
        end
      end
      SAMPLE: begin
        if (bus.ABORT) begin
          passNext  = 1'b0;
          stateNext = IDLE;
        end else begin
          mismatch = (ySync[1] != TRUTH[vec]);
          if (mismatch) begin
            errCntNext = errCnt + 4'd1;
            if (!failVld) begin
              failVldNext = 1'b1;
              failVecNext = vec;
            end
          end
          if (vec == 3'd7) begin
            // PASS must already reflect the final sample during the DONE cycle.
            passNext  = (errCnt == 4'd0) && !mismatch;
            stateNext = FINISH;
          end else begin
            vecNext       = vec + 3'd1;
            settleCntNext = 8'(SETTLE_CYCLES - 1);
            stateNext     = SETTLE;
          end
        end
      end
      FINISH: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Cell inputs are registered from the next-state vector so they change only on clock edges.
    cellInNext = (stateNext == SETTLE || stateNext == SAMPLE) ? vecNext : 3'd0;
  end

  assign bus.A        = cellIn[2];
  assign bus.B1       = cellIn[1];
  assign bus.B2       = cellIn[0];
  assign bus.BUSY     = (state == SETTLE) || (state == SAMPLE);
  assign bus.DONE     = (state == FINISH);
  assign bus.PASS     = pass;
  assign bus.ERR_CNT  = errCnt;
  assign bus.FAIL_VLD = failVld;
  assign bus.FAIL_VEC = failVec;
  assign bus.dbgState = state;

endmodule

// File: doc/cell_test_sequencer.md
Name: cell_test_sequencer

Overview:
- Self-test controller for one AOI21 cell instance (Y = ~(A | (B1 & B2))) inside the RV523 cell-characterisation harness.
- Drives all 8 input vectors into the cell, waits a programmable settle time, and samples the cell output through a 2-flop synchroniser.
- Compares each sample against a truth-table parameter and reports an error count, the first failing vector and a PASS flag.
- Sits between the harness control logic (START/ABORT) and the transistor-level cell under test.

Parameters:
- TRUTH, 8'h07, expected Y for each vector index {A,B1,B2}; bit k = expected Y for index k. 8'h07 encodes AOI21.
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 3..255. Values of 3 or more cover 2 synchroniser stages plus 1 cycle of cell settling.

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset
- START  in  1  begin test run; sampled only in IDLE
- ABORT  in  1  cancel run in progress
- Y_IN  in  1  asynchronous cell output Y
- A  out  1  cell input A, registered
- B1  out  1  cell input B1, registered
- B2  out  1  cell input B2, registered
- BUSY  out  1  high while in SETTLE or SAMPLE
- DONE  out  1  one-cycle pulse when a run completes
- PASS  out  1  1 if the last completed run had zero mismatches
- ERR_CNT  out  4  mismatch count of the current or last run (0..8)
- FAIL_VLD  out  1  at least one mismatch recorded
- FAIL_VEC  out  3  index {A,B1,B2} of the first mismatch

Behaviour:
- Reset (RST_N low at a clock edge):
  - State goes to IDLE.
  - A, B1, B2, BUSY, DONE, PASS, FAIL_VLD = 0; ERR_CNT = 0; FAIL_VEC = 0; synchroniser flops = 0; vector and settle counters = 0.
  - Reset in the middle of a run has the same effect; no DONE is produced.
- Synchroniser: Y_IN passes through two flops to y_s. Only y_s is compared.
- State IDLE:
  - {A,B1,B2} = 000.
  - START=1 causes, on the next edge: vec=0; ERR_CNT, FAIL_VLD, FAIL_VEC and PASS cleared; settle counter = SETTLE_CYCLES-1; state goes to SETTLE.
- State SETTLE:
  - {A,B1,B2} = vec.
  - Counter decrements each cycle; when it reaches 0, state goes to SAMPLE.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- State SAMPLE (1 cycle):
  - If y_s != TRUTH[vec]: ERR_CNT++. If FAIL_VLD=0, also set FAIL_VLD=1 and FAIL_VEC=vec.
  - If vec==7, go to FINISH.
  - Otherwise vec++, reload the counter and go to SETTLE. The new vector appears on A/B1/B2 in the first SETTLE cycle.
- State FINISH (1 cycle):
  - DONE=1; PASS=(ERR_CNT==0), using the count including the final sample.
  - {A,B1,B2} = 000; return to IDLE.
- Timing: START accepted at edge t0 gives BUSY=1 during cycles t0+1 .. t0+8*(SETTLE_CYCLES+1), and DONE=1 in cycle t0+8*(SETTLE_CYCLES+1)+1. With the default of 4, BUSY lasts 40 cycles and DONE is at t0+41.
- ABORT=1 in SETTLE or SAMPLE:
  - Next state is IDLE; {A,B1,B2} = 000; PASS = 0.
  - ERR_CNT, FAIL_VLD and FAIL_VEC hold their partial values.
  - No DONE. The mismatch check in that SAMPLE cycle is suppressed.
  - ABORT in IDLE or FINISH is ignored; FINISH completes normally.
- Priority: RST_N > ABORT > normal sequencing.
- START while BUSY or in FINISH is ignored.
- Results hold until the next accepted START or reset.
- ERR_CNT cannot exceed 8; no wrap is possible.
- A, B1 and B2 come straight from flops, with no combinational path from inputs, so they are glitch-free into the cell.

Test Plan:
- Good AOI21 behavioural model on Y_IN, SETTLE_CYCLES=4, START pulse at t0 -> A/B1/B2 step 000..111 with 5 cycles per vector; BUSY high t0+1..t0+40; DONE single pulse at t0+41; PASS=1, ERR_CNT=0, FAIL_VLD=0.
- Y_IN stuck at 0 -> ERR_CNT=3, FAIL_VLD=1, FAIL_VEC=0, PASS=0.
- Y_IN stuck at 1 -> ERR_CNT=5, FAIL_VEC=3, PASS=0.
- B2 open fault model Y=~(A|B1) -> ERR_CNT=1, FAIL_VEC=2, PASS=0.
- ABORT at t0+12 (vector 2, SETTLE) -> IDLE next cycle; BUSY=0, A/B1/B2=000, no DONE, PASS=0. A following START with the good model runs the full sequence, then PASS=1.
- RST_N low for 1 cycle at t0+20 -> all outputs 0 on the following cycle with no DONE. START asserted while BUSY during a fresh run -> no effect on vec or timing.
